posit_encoder_pipe: RTL

//  Packs unpacked posit fields into an N-bit posit word: sign, regime k, exponent, fraction and sticky.

---
 rtl/posit_encoder_pipe.sv | 180 ++++++++++++++++++
 1 files changed

// File: rtl/posit_encoder_pipe.sv
// posit_encoder_pipe
// Packs unpacked posit fields (sign, regime k, exponent, fraction, sticky)
// into an N-bit posit word. Rounds to nearest with ties to even. Saturates
// to maxpos/minpos. Two-stage pipeline with valid/ready on both sides.
//
// Ports:
//   clk, rst          clock (rising edge), synchronous active-high reset
//   in_valid/in_ready input handshake
//   in_is_zero        value is exactly zero
//   in_is_inf         value is NaR (takes priority over in_is_zero)
//   in_sign           1 = negative
//   in_k              regime value, two's complement, N bits
//   in_exp            exponent field, EW bits (unused when ES = 0)
//   in_mant           fraction after the hidden 1, MSB weight 2^-1
//   in_sticky         OR of fraction bits below in_mant[0]
//   out_valid/out_ready output handshake
//   out_posit         encoded posit
//   out_inexact       rounding or saturation changed the value
module posit_encoder_pipe #(
   parameter int N  = 8,
   parameter int ES = 0,
   localparam int EW = (ES > 0) ? ES : 1
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          in_valid,
   output logic          in_ready,
   input  logic          in_is_zero,
   input  logic          in_is_inf,
   input  logic          in_sign,
   input  logic [N-1:0]  in_k,
   input  logic [EW-1:0] in_exp,
   input  logic [N-1:0]  in_mant,
   input  logic          in_sticky,
   output logic          out_valid,
   input  logic          out_ready,
   output logic [N-1:0]  out_posit,
   output logic          out_inexact
);

   // Width of the exponent+fraction tail, and of the scratch vector that
   // holds the regime followed by that tail.
   localparam int T = ES + N;
   localparam int L = N + T;

   logic [T-1:0] tail;

   // With ES = 0 the exponent port exists only to keep a legal width.
   if (ES == 0) begin : g_noexp
      logic unused_exp;
      assign unused_exp = ^in_exp;
      assign tail = in_mant;
   end else begin : g_exp
      assign tail = {in_exp, in_mant};
   end

   logic         s1_valid;
   logic [N-2:0] s1_body;
   logic         s1_guard;
   logic         s1_sticky;
   logic         s1_sign;
   logic         s1_zero;
   logic         s1_inf;
   logic         s1_sat_max;
   logic         s1_sat_min;

   logic s2_load;
   logic s1_load;

   assign s2_load  = !out_valid || out_ready;
   assign s1_load  = !s1_valid || s2_load;
   assign in_ready = s1_load && !rst;

   int           k_val;
   int           r_len;
   logic [L-1:0] reg_bits;
   logic [L-1:0] tail_shift;
   logic [L-1:0] full_vec;
   logic [N-2:0] b_body;
   logic         b_guard;
   logic         b_sticky;
   logic         b_sat_max;
   logic         b_sat_min;

   // Stage 1: lay the regime at the top of a wide vector, slide the tail in
   // right behind it, then cut to N-1 body bits plus guard and sticky.
   // A k>=0 regime is r_len-1 ones and a terminating zero; a k<0 regime is
   // r_len-1 zeros and a terminating one. Either way r_len = |k| + 1 or k+2.
   always_comb begin
      k_val      = int'(signed'(in_k));
      b_sat_max  = k_val > N - 2;
      b_sat_min  = k_val < -(N - 2);
      r_len      = (k_val >= 0) ? k_val + 2 : 1 - k_val;
      tail_shift = {tail, {N{1'b0}}} >> r_len;
      if (k_val >= 0)
         reg_bits = ~({L{1'b1}} >> (r_len - 1));
      else
         reg_bits = {1'b1, {(L-1){1'b0}}} >> (r_len - 1);
      full_vec = reg_bits | tail_shift;
      b_body   = full_vec[L-1 -: N-1];
      b_guard  = full_vec[L-N];
      b_sticky = (|full_vec[L-N-1:0]) || in_sticky;
   end

   logic         round_up;
   logic [N-1:0] sum;
   logic [N-2:0] mag;
   logic         mag_inexact;
   logic [N-1:0] word;
   logic [N-1:0] s2_posit;
   logic         s2_inexact;

   // Stage 2: round, then clamp. Any carry out of the body or a result of
   // zero means the true value is outside the representable magnitude range,
   // so it is pinned to maxpos/minpos and flagged inexact.
   always_comb begin
      round_up = s1_guard && (s1_sticky || s1_body[0]);
      sum      = {1'b0, s1_body} + {{(N-1){1'b0}}, round_up};
      if (s1_sat_max) begin
         mag         = {(N-1){1'b1}};
         mag_inexact = 1'b1;
      end else if (s1_sat_min) begin
         mag         = {{(N-2){1'b0}}, 1'b1};
         mag_inexact = 1'b1;
      end else if (sum[N-1]) begin
         mag         = {(N-1){1'b1}};
         mag_inexact = 1'b1;
      end else if (sum[N-2:0] == '0) begin
         mag         = {{(N-2){1'b0}}, 1'b1};
         mag_inexact = 1'b1;
      end else begin
         mag         = sum[N-2:0];
         mag_inexact = s1_guard || s1_sticky;
      end
      word = {1'b0, mag};
      if (s1_inf) begin
         s2_posit   = {1'b1, {(N-1){1'b0}}};
         s2_inexact = 1'b0;
      end else if (s1_zero) begin
         s2_posit   = '0;
         s2_inexact = 1'b0;
      end else begin
         s2_posit   = s1_sign ? (~word + 1'b1) : word;
         s2_inexact = mag_inexact;
      end
   end

   // Pipeline registers. Each stage keeps its payload when it holds no
   // valid item, so only the valid flags need reset to drop in-flight data.
   always_ff @(posedge clk) begin
      if (rst) begin
         s1_valid    <= 1'b0;
         out_valid   <= 1'b0;
         out_posit   <= '0;
         out_inexact <= 1'b0;
      end else begin
         if (s2_load) begin
            out_valid <= s1_valid;
            if (s1_valid) begin
               out_posit   <= s2_posit;
               out_inexact <= s2_inexact;
            end
         end
         if (s1_load) begin
            s1_valid <= in_valid;
            if (in_valid) begin
               s1_body    <= b_body;
               s1_guard   <= b_guard;
               s1_sticky  <= b_sticky;
               s1_sign    <= in_sign;
               s1_zero    <= in_is_zero;
               s1_inf     <= in_is_inf;
               s1_sat_max <= b_sat_max;
               s1_sat_min <= b_sat_min;
            end
         end
      end
   end

endmodule
